gpio_axil_req_arbiter: RTL and testbench

//  Shares one AXI4-Lite master port between NUM_REQ simple register-access requesters.

---
 rtl/gpio_axil_req_arbiter.sv | 157 +++++++++++++++
 tb/tb_gpio_axil_req_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_axil_req_arbiter.sv
// gpio_axil_req_arbiter: round-robin sharing of one AXI4-Lite master among NUM_REQ register requesters
// Define GPIO_ARB_TIMEOUT_EN to add a response watchdog that aborts with SLVERR after TIMEOUT_CYCLES.
module gpio_axil_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]     req_wdata,
  input  logic [NUM_REQ*4-1:0]      req_wstrb,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [ADDR_W-1:0]         m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [31:0]               m_axi_wdata,
  output logic [3:0]                m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [ADDR_W-1:0]         m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [31:0]               m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [2:0] {IDLE, WR, WB, RA, RR} state_t;
  state_t state;
  logic [PW-1:0] ptr, cur, gnt, idx;
  logic gnt_any, timeout;
  logic [ADDR_W-1:0] gnt_addr;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  // descending scan so the requester closest to ptr wins
  always_comb begin
    gnt_any = 1'b0;
    gnt = '0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NUM_REQ);
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt = idx;
      end
    end
    gnt_addr = req_addr[gnt*ADDR_W +: ADDR_W];
  end
`ifdef GPIO_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t prev;
  logic [CW-1:0] cnt, cnt_cur;
  assign cnt_cur = (state != prev) ? '0 : cnt;
  assign timeout = (state != IDLE) && (cnt_cur == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      prev <= IDLE;
      cnt <= '0;
    end else begin
      prev <= state;
      cnt <= (state == IDLE) ? '0 : cnt_cur + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
      ptr <= '0;
      cur <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_resp <= '0;
      m_axi_awaddr <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata <= '0;
      m_axi_wstrb <= '0;
      m_axi_wvalid <= 1'b0;
      m_axi_bready <= 1'b0;
      m_axi_araddr <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      if (timeout) begin
        {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} <= '0;
        rsp_valid <= NUM_REQ'(1) << cur;
        rsp_resp <= 2'b10;
        rsp_rdata <= '0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (gnt_any) begin
            req_ready <= NUM_REQ'(1) << gnt;
            cur <= gnt;
            ptr <= (gnt == PW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
            if (req_write[gnt]) begin
              m_axi_awaddr <= {gnt_addr[ADDR_W-1:2], 2'b00};
              m_axi_wdata <= req_wdata[gnt*32 +: 32];
              m_axi_wstrb <= req_wstrb[gnt*4 +: 4];
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid <= 1'b1;
              state <= WR;
            end else begin
              m_axi_araddr <= {gnt_addr[ADDR_W-1:2], 2'b00};
              m_axi_arvalid <= 1'b1;
              state <= RA;
            end
          end
          WR: begin
            if (m_axi_awready) m_axi_awvalid <= 1'b0;
            if (m_axi_wready) m_axi_wvalid <= 1'b0;
            if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
              m_axi_bready <= 1'b1;
              state <= WB;
            end
          end
          WB: if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << cur;
            rsp_resp <= m_axi_bresp;
            rsp_rdata <= '0;
            state <= IDLE;
          end
          RA: if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready <= 1'b1;
            state <= RR;
          end
          RR: if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << cur;
            rsp_resp <= m_axi_rresp;
            rsp_rdata <= m_axi_rdata;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gpio_axil_req_arbiter.sv
// tb_gpio_axil_req_arbiter: randomized requesters and AXI4-Lite slave against a
// transaction-level model (grant order, memory contents, response routing).
module tb_gpio_axil_req_arbiter;
  localparam int N = 3;
  logic ACLK = 1'b0, ARESETN = 1'b0;
  logic [N-1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [N*4-1:0] req_addr, req_wstrb;
  logic [N*32-1:0] req_wdata;
  logic [31:0] rsp_rdata, m_axi_wdata, m_axi_rdata;
  logic [1:0] rsp_resp, m_axi_bresp, m_axi_rresp;
  logic [3:0] m_axi_awaddr, m_axi_araddr, m_axi_wstrb;
  logic [2:0] m_axi_awprot, m_axi_arprot;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
  logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;

  gpio_axil_req_arbiter #(.NUM_REQ(N), .ADDR_W(4), .TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 ACLK = ~ACLK;

  // requester-side stimulus
  logic [N-1:0] rv, rw;
  logic [3:0] ra [N];
  logic [31:0] rd [N];
  logic [3:0] rs [N];
  always_comb begin
    req_valid = rv;
    req_write = rw;
    req_addr = '0;
    req_wdata = '0;
    req_wstrb = '0;
    for (int k = 0; k < N; k++) begin
      req_addr[k*4 +: 4] = ra[k];
      req_wdata[k*32 +: 32] = rd[k];
      req_wstrb[k*4 +: 4] = rs[k];
    end
  end

  // AXI4-Lite slave with programmable latencies
  logic [31:0] s_mem [4];
  logic [3:0] s_awaddr, s_araddr, s_wstrb;
  logic [31:0] s_wdata;
  logic [1:0] s_resp;
  bit got_aw, got_w, pend_b, pend_r, b_never;
  int aw_lat, w_lat, ar_lat, b_lat, r_lat;
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;
  int aw_hs, w_hs, ar_hs;

  always @(posedge ACLK) begin
    if (!ARESETN) begin
      got_aw = 0; got_w = 0; pend_b = 0; pend_r = 0;
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin got_aw = 1; s_awaddr = m_axi_awaddr; aw_hs++; end
      if (m_axi_wvalid && m_axi_wready) begin got_w = 1; s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb; w_hs++; end
      if (m_axi_bvalid && m_axi_bready) pend_b = 0;
      if (got_aw && got_w) begin
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) s_mem[s_awaddr[3:2]][8*b +: 8] = s_wdata[8*b +: 8];
        got_aw = 0; got_w = 0; pend_b = 1;
      end
      if (m_axi_rvalid && m_axi_rready) pend_r = 0;
      if (m_axi_arvalid && m_axi_arready) begin ar_hs++; s_araddr = m_axi_araddr; pend_r = 1; end
    end
  end

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    end else begin
      if (!m_axi_awvalid) aw_wait = 0;
      m_axi_awready = m_axi_awvalid && aw_wait >= aw_lat;
      if (m_axi_awvalid) aw_wait++;
      if (!m_axi_wvalid) w_wait = 0;
      m_axi_wready = m_axi_wvalid && w_wait >= w_lat;
      if (m_axi_wvalid) w_wait++;
      if (!m_axi_arvalid) ar_wait = 0;
      m_axi_arready = m_axi_arvalid && ar_wait >= ar_lat;
      if (m_axi_arvalid) ar_wait++;
      if (!pend_b) b_wait = 0;
      m_axi_bvalid = pend_b && !b_never && b_wait >= b_lat;
      if (pend_b) b_wait++;
      if (!pend_r) r_wait = 0;
      m_axi_rvalid = pend_r && r_wait >= r_lat;
      if (pend_r) r_wait++;
    end
    m_axi_bresp = s_resp;
    m_axi_rresp = s_resp;
    m_axi_rdata = pend_r ? s_mem[s_araddr[3:2]] : 32'h0;
  end

  // reference model: round-robin pointer and register contents
  int mptr;
  logic [31:0] mmem [4];
  bit expect_to;
  int order [$];
  logic [31:0] last_rdata;
  logic [1:0] last_resp;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] p);
    for (int i = 0; i < N; i++)
      if (p[(mptr + i) % N]) return (mptr + i) % N;
    return -1;
  endfunction

  task automatic run_batch(input logic [N-1:0] mask);
    int left, cur, g, w;
    bit e_wr;
    logic [31:0] e_rdata, e_data;
    logic [3:0] e_addr, e_strb;
    logic [1:0] e_resp;
    left = $countones(mask);
    cur = 0; e_wr = 0; e_rdata = 0; e_data = 0; e_addr = 0; e_strb = 0; e_resp = 0;
    order.delete();
    @(negedge ACLK);
    rv = mask;
    for (int c = 0; c < 300 && left > 0; c++) begin
      @(negedge ACLK);
      if (req_ready != 0) begin
        g = model_grant(rv);
        chk("grant", 32'(req_ready), 32'(1) << g);
        order.push_back(g);
        cur = g;
        mptr = (g + 1) % N;
        e_wr = rw[g];
        e_addr = ra[g] & 4'hC;
        e_data = rd[g];
        e_strb = rs[g];
        w = int'(ra[g]) / 4;
        if (e_wr) begin
          for (int b = 0; b < 4; b++)
            if (e_strb[b]) mmem[w][8*b +: 8] = e_data[8*b +: 8];
          e_rdata = 0;
        end else e_rdata = mmem[w];
        e_resp = s_resp;
        if (expect_to) begin e_resp = 2'b10; e_rdata = 0; end
        aw_hs = 0; w_hs = 0; ar_hs = 0;
        rv[g] = 1'b0;
      end
      if (rsp_valid != 0) begin
        chk("rsp_route", 32'(rsp_valid), 32'(1) << cur);
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_resp", 32'(rsp_resp), 32'(e_resp));
        last_rdata = rsp_rdata;
        last_resp = rsp_resp;
        if (e_wr) begin
          chk("aw_count", aw_hs, 1);
          chk("w_count", w_hs, 1);
          chk("awaddr", 32'(s_awaddr), 32'(e_addr));
          chk("wdata", s_wdata, e_data);
          chk("wstrb", 32'(s_wstrb), 32'(e_strb));
        end else begin
          chk("ar_count", ar_hs, 1);
          chk("araddr", 32'(s_araddr), 32'(e_addr));
        end
        left--;
      end
    end
    chk("batch_done", left, 0);
    rv = '0;
    repeat (2) begin
      @(negedge ACLK);
      chk("quiet", 32'({req_ready, rsp_valid}), 0);
    end
  endtask

  task automatic do_reset();
    rv = '0;
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    mptr = 0;
    @(negedge ACLK);
  endtask

  task automatic set_req(input int k, input bit wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    rw[k] = wr; ra[k] = a; rd[k] = d; rs[k] = s;
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 4; i++) begin s_mem[i] = 0; mmem[i] = 0; end
    for (int k = 0; k < N; k++) set_req(k, 0, 0, 0, 0);
    rv = '0; mptr = 0; expect_to = 0; b_never = 0; s_resp = 0;
    aw_lat = 0; w_lat = 0; ar_lat = 0; b_lat = 0; r_lat = 0;
    aw_hs = 0; w_hs = 0; ar_hs = 0; last_rdata = 0; last_resp = 0;
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("rst_ctl", 32'({req_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 0);
    chk("rst_data", {rsp_rdata[23:0], rsp_resp, m_axi_awaddr, m_axi_wstrb}, 0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("idle_ctl", 32'({req_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 0);

    // write 1..4 from requester 0, read back from requester 1
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, 4'(i * 4), 32'(i + 1), 4'hF);
      run_batch(3'b001);
    end
    for (int i = 0; i < 4; i++) begin
      set_req(1, 0, 4'(i * 4), 0, 0);
      run_batch(3'b010);
      chk("readback", last_rdata, 32'(i + 1));
      chk("readback_resp", 32'(last_resp), 0);
    end

    // simultaneous requests straight after reset, then rotation
    do_reset();
    set_req(0, 0, 4'h0, 0, 0);
    set_req(1, 0, 4'h4, 0, 0);
    set_req(2, 0, 4'h8, 0, 0);
    run_batch(3'b011);
    chk("rr_first", order[0], 0);
    chk("rr_second", order[1], 1);
    run_batch(3'b011);
    chk("rr_again", order[0], 0);
    run_batch(3'b111);
    chk("rr_rot0", order[0], 2);
    chk("rr_rot1", order[1], 0);
    chk("rr_rot2", order[2], 1);

    // skewed AW / W acceptance in both directions
    aw_lat = 3; w_lat = 0;
    set_req(2, 1, 4'hC, 32'h1234_5678, 4'hF);
    run_batch(3'b100);
    aw_lat = 0; w_lat = 3;
    set_req(0, 1, 4'h8, 32'h9ABC_DEF0, 4'hF);
    run_batch(3'b001);
    w_lat = 0;

    // unaligned address and partial strobe
    set_req(1, 1, 4'h7, 32'hAABB_CCDD, 4'b0010);
    run_batch(3'b010);
    chk("align_awaddr", 32'(s_awaddr), 32'h4);
    chk("strb_pass", 32'(s_wstrb), 32'h2);
    set_req(0, 0, 4'h4, 0, 0);
    run_batch(3'b001);

`ifdef GPIO_ARB_TIMEOUT_EN
    b_never = 1; expect_to = 1;
    set_req(0, 1, 4'h0, 32'h5555_0000, 4'hF);
    run_batch(3'b001);
    chk("timeout_resp", 32'(last_resp), 32'h2);
    b_never = 0; expect_to = 0; pend_b = 0;
    set_req(1, 0, 4'h0, 0, 0);
    run_batch(3'b010);
`endif

    // reset while waiting for read data
    r_lat = 6;
    set_req(1, 0, 4'h8, 0, 0);
    @(negedge ACLK);
    rv = 3'b010;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge ACLK);
      if (req_ready != 0) rv = '0;
      if (m_axi_rready) found = 1;
    end
    chk("reach_rr", 32'(found), 1);
    ARESETN = 1'b0;
    #1;
    chk("rst_drop", 32'({m_axi_rready, m_axi_arvalid, rsp_valid, req_ready}), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      chk("rst_no_rsp", 32'(rsp_valid), 0);
    end
    ARESETN = 1'b1;
    mptr = 0; r_lat = 0;
    set_req(0, 0, 4'h0, 0, 0);
    run_batch(3'b011);
    chk("post_rst_first", order[0], 0);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); ar_lat = $urandom_range(0, 3);
      b_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
      s_resp = 2'($urandom_range(0, 1));
      for (int k = 0; k < N; k++)
        set_req(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      run_batch(3'($urandom_range(1, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
